// File: rtl/search_clock_pkg.sv
// Shared types and constants for the search clock and its millisecond prescaler.
package search_clock_pkg;

    // Millisecond quantity, unsigned 32-bit.
    typedef logic [31:0] ms_t;

    // Top-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned MS_PER_S = 1000;

endpackage

// File: rtl/search_clock_ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every CLOCK_FREQ/MS_PER_S
// enabled cycles. clear_in reloads the count so the next tick is a full
// millisecond away.
module ms_tick_gen
    import search_clock_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic enable_in,
    output logic tick_out
);

    localparam logic [31:0] RELOAD = 32'(CLOCK_FREQ / MS_PER_S - 1);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: reload on clear, otherwise count down and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_in) begin
            cnt_d = RELOAD;
        end else if (enable_in) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 32'd1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_out = enable_in && !clear_in && (cnt_q == '0);

endmodule

// File: rtl/search_clock.sv
// Per-move search time manager. On go it latches the clock and increment,
// spends one cycle computing a budget, then counts it down in milliseconds
// and pulses expired_out when it runs out. Elapsed time is exported too.
// Optional macro SEARCH_CLOCK_OVERHEAD_EN subtracts MOVE_OVERHEAD_MS from
// the budget to cover UART and bestmove latency.
module search_clock
    import search_clock_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ       = 50_000_000,
    parameter int unsigned TIME_SHIFT       = 5,
    parameter int unsigned CAP_SHIFT        = 3,
    parameter int unsigned MIN_BUDGET_MS    = 1,
    parameter int unsigned MOVE_OVERHEAD_MS = 20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        go_in,
    input  logic [31:0] time_ms_in,
    input  logic [31:0] inc_ms_in,
    input  logic        stop_in,
    output logic        active_out,
    output logic [31:0] budget_ms_out,
    output logic [31:0] remaining_ms_out,
    output logic [31:0] elapsed_ms_out,
    output logic        expired_out
);

`ifdef SEARCH_CLOCK_OVERHEAD_EN
    localparam int unsigned OVERHEAD_EN = 1;
`else
    localparam int unsigned OVERHEAD_EN = 0;
`endif

    // With the overhead disabled the subtraction is by zero, which leaves
    // every budget unchanged (b is already >= MIN when time is non-zero).
    localparam ms_t OVERHEAD_MS = ms_t'(MOVE_OVERHEAD_MS * OVERHEAD_EN);
    localparam ms_t MIN_MS      = ms_t'(MIN_BUDGET_MS);

    state_t state_q, state_d;
    ms_t    time_q, time_d;
    ms_t    inc_q, inc_d;
    ms_t    budget_q, budget_d;
    ms_t    rem_q, rem_d;
    ms_t    el_q, el_d;
    logic   exp_q, exp_d;

    logic        tick;
    ms_t         base;
    ms_t         sum_sat;
    ms_t         cap;
    ms_t         b;
    logic [32:0] sum_wide;

    ms_tick_gen #(
        .CLOCK_FREQ(CLOCK_FREQ)
    ) u_tick (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (state_q == CALC),
        .enable_in(state_q == RUN),
        .tick_out (tick)
    );

    // Budget arithmetic from the latched clock and increment.
    always_comb begin
        base     = time_q >> TIME_SHIFT;
        sum_wide = {1'b0, base} + {1'b0, inc_q};
        sum_sat  = sum_wide[32] ? '1 : sum_wide[31:0];
        cap      = time_q >> CAP_SHIFT;
        b        = (sum_sat < cap) ? sum_sat : cap;
        if (time_q == '0)     b = '0;
        else if (b < MIN_MS)  b = MIN_MS;
        if (b > OVERHEAD_MS)  b = b - OVERHEAD_MS;
        else                  b = (time_q != '0) ? MIN_MS : '0;
    end

    // Next-state and datapath: go beats stop; a tick in RUN always lands.
    always_comb begin
        state_d  = state_q;
        time_d   = time_q;
        inc_d    = inc_q;
        budget_d = budget_q;
        rem_d    = rem_q;
        el_d     = el_q;
        exp_d    = 1'b0;

        if (state_q == RUN && tick) begin
            if (rem_q != '0) rem_d = rem_q - 32'd1;
            if (el_q != '1)  el_d  = el_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (go_in) begin
                    time_d  = time_ms_in;
                    inc_d   = inc_ms_in;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (go_in) begin
                    time_d = time_ms_in;
                    inc_d  = inc_ms_in;
                end else if (stop_in) begin
                    state_d = IDLE;
                end else begin
                    budget_d = b;
                    rem_d    = b;
                    el_d     = '0;
                    if (b == '0) begin
                        exp_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (go_in) begin
                    time_d  = time_ms_in;
                    inc_d   = inc_ms_in;
                    state_d = CALC;
                end else if (stop_in) begin
                    state_d = IDLE;
                end else if (tick && rem_q == 32'd1) begin
                    exp_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            time_q   <= '0;
            inc_q    <= '0;
            budget_q <= '0;
            rem_q    <= '0;
            el_q     <= '0;
            exp_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            inc_q    <= inc_d;
            budget_q <= budget_d;
            rem_q    <= rem_d;
            el_q     <= el_d;
            exp_q    <= exp_d;
        end
    end

    assign active_out       = (state_q == RUN);
    assign budget_ms_out    = budget_q;
    assign remaining_ms_out = rem_q;
    assign elapsed_ms_out   = el_q;
    assign expired_out      = exp_q;

endmodule

// File: tb/tb_search_clock.sv
// Bench for search_clock at CLOCK_FREQ=4000 (4 cycles per ms). A cycle-count
// reference model predicts every output; directed scenarios add literal checks.
module tb_search_clock;

  localparam int unsigned CYC_PER_MS = 4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        go_in;
  logic [31:0] time_ms_in;
  logic [31:0] inc_ms_in;
  logic        stop_in;
  logic        active_out;
  logic [31:0] budget_ms_out;
  logic [31:0] remaining_ms_out;
  logic [31:0] elapsed_ms_out;
  logic        expired_out;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_cnt = 0;

  search_clock #(.CLOCK_FREQ(4000)) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .go_in           (go_in),
    .time_ms_in      (time_ms_in),
    .inc_ms_in       (inc_ms_in),
    .stop_in         (stop_in),
    .active_out      (active_out),
    .budget_ms_out   (budget_ms_out),
    .remaining_ms_out(remaining_ms_out),
    .elapsed_ms_out  (elapsed_ms_out),
    .expired_out     (expired_out)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // budget from the rules, in wide arithmetic
  function automatic logic [31:0] ref_budget(input logic [31:0] t, input logic [31:0] i);
    longint s;
    longint c;
    longint r;
    s = longint'(t / 32) + longint'(i);
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    c = longint'(t / 8);
    r = (s < c) ? s : c;
    if (t == 0) return 32'd0;
    if (r < 1) r = 1;
`ifdef SEARCH_CLOCK_OVERHEAD_EN
    if (r > 20) r = r - 20;
    else r = 1;
`endif
    return r[31:0];
  endfunction

  // reference model: time is tracked as cycles since the budget was loaded
  int          m_phase;   // 0 waiting, 1 computing, 2 counting
  logic [31:0] m_t, m_i, m_b, m_budget, m_rem, m_el;
  longint      m_k;
  logic        m_exp, m_act;

  always @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      m_phase = 0; m_t = 0; m_i = 0; m_b = 0; m_budget = 0;
      m_rem = 0; m_el = 0; m_k = 0; m_exp = 0;
    end else begin
      m_exp = 0;
      if (m_phase == 2) begin
        m_k++;
        m_el  = 32'(m_k / CYC_PER_MS);
        m_rem = m_b - 32'(m_k / CYC_PER_MS);
        if (go_in) begin
          m_t = time_ms_in; m_i = inc_ms_in; m_phase = 1;
        end else if (stop_in) begin
          m_phase = 0;
        end else if (m_k == longint'(m_b) * CYC_PER_MS) begin
          m_exp = 1; m_phase = 0;
        end
      end else if (m_phase == 1) begin
        if (go_in) begin
          m_t = time_ms_in; m_i = inc_ms_in;
        end else if (stop_in) begin
          m_phase = 0;
        end else begin
          m_b = ref_budget(m_t, m_i);
          m_budget = m_b; m_rem = m_b; m_el = 0; m_k = 0;
          if (m_b == 0) begin
            m_exp = 1; m_phase = 0;
          end else begin
            m_phase = 2;
          end
        end
      end else if (go_in) begin
        m_t = time_ms_in; m_i = inc_ms_in; m_phase = 1;
      end
    end
    m_act = (m_phase == 2);
  end

  // scoreboard: every cycle out of reset, on the falling edge
  always @(negedge clk) begin
    if (expired_out) exp_cnt++;
    if (!rst_in) begin
      chk("active", {31'b0, active_out}, {31'b0, m_act});
      chk("budget", budget_ms_out, m_budget);
      chk("remaining", remaining_ms_out, m_rem);
      chk("elapsed", elapsed_ms_out, m_el);
      chk("expired", {31'b0, expired_out}, {31'b0, m_exp});
    end
  end

  // driver tasks
  task automatic do_go(input logic [31:0] t, input logic [31:0] i);
    @(posedge clk); #1;
    go_in = 1'b1; stop_in = 1'b0; time_ms_in = t; inc_ms_in = i;
    @(posedge clk); #1;
    go_in = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1; stop_in = 1'b1;
    @(posedge clk); #1; stop_in = 1'b0;
  endtask

  task automatic wait_expire(input string name, input int bound, output int n);
    n = 0;
    while (!expired_out && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!expired_out) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int snap;
    logic [31:0] t, i;

    rst_in = 1'b1; go_in = 1'b0; stop_in = 1'b0; time_ms_in = 0; inc_ms_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_active", {31'b0, active_out}, 32'd0);
    chk("rst_budget", budget_ms_out, 32'd0);
    chk("rst_remaining", remaining_ms_out, 32'd0);
    chk("rst_expired", {31'b0, expired_out}, 32'd0);
    #3 rst_in = 1'b0;

    // model pins
    chk("ref_60000_1000", ref_budget(32'd60000, 32'd1000), 32'd2875);
    chk("ref_64_0", ref_budget(32'd64, 32'd0), 32'd2);
    chk("ref_0_500", ref_budget(32'd0, 32'd500), 32'd0);

    // long search runs to expiry
    do_go(32'd60000, 32'd1000);
    @(posedge clk); #1;
    chk("t1_budget", budget_ms_out, 32'd2875);
    chk("t1_active", {31'b0, active_out}, 32'd1);
    wait_expire("t1", 12000, n);
    chk("t1_cycles", n, 32'd11500);
    chk("t1_elapsed", elapsed_ms_out, 32'd2875);
    chk("t1_remaining", remaining_ms_out, 32'd0);

    // cap case
    do_go(32'd800, 32'd1000);
    @(posedge clk); #1;
`ifdef SEARCH_CLOCK_OVERHEAD_EN
    chk("t2_budget", budget_ms_out, 32'd80);
`else
    chk("t2_budget", budget_ms_out, 32'd100);
`endif
    do_stop();

    // zero clock: immediate expiry, never active
    repeat (3) @(posedge clk);
    snap = exp_cnt;
    do_go(32'd0, 32'd500);
    chk("t3_active_calc", {31'b0, active_out}, 32'd0);
    @(posedge clk); #1;
    chk("t3_budget", budget_ms_out, 32'd0);
    chk("t3_expired", {31'b0, expired_out}, 32'd1);
    chk("t3_active", {31'b0, active_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_pulses", exp_cnt - snap, 32'd1);

    // stop mid-count: values hold, no pulse
    snap = exp_cnt;
    do_go(32'd64, 32'd0);
    @(posedge clk); #1;
    chk("t4_budget", budget_ms_out, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    stop_in = 1'b1;
    @(posedge clk); #1;
    stop_in = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t4_remaining", remaining_ms_out, 32'd1);
    chk("t4_elapsed", elapsed_ms_out, 32'd1);
    chk("t4_active", {31'b0, active_out}, 32'd0);
    chk("t4_pulses", exp_cnt - snap, 32'd0);

    // restart abandons the first countdown
    snap = exp_cnt;
    do_go(32'd60000, 32'd0);
    repeat (40) @(posedge clk);
    do_go(32'd32000, 32'd0);
    @(posedge clk); #1;
    chk("t5_budget", budget_ms_out, 32'd1000);
    chk("t5_elapsed", elapsed_ms_out, 32'd0);
    wait_expire("t5", 4500, n);
    chk("t5_cycles", n, 32'd4000);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pulses", exp_cnt - snap, 32'd1);

    // asynchronous reset mid-count
    do_go(32'd60000, 32'd1000);
    repeat (100) @(posedge clk);
    #2 rst_in = 1'b1;
    #1;
    chk("t6_active", {31'b0, active_out}, 32'd0);
    chk("t6_budget", budget_ms_out, 32'd0);
    chk("t6_remaining", remaining_ms_out, 32'd0);
    chk("t6_elapsed", elapsed_ms_out, 32'd0);
    snap = exp_cnt;
    repeat (3) @(posedge clk);
    #3 rst_in = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t6_pulses", exp_cnt - snap, 32'd0);
    chk("t6_idle", {31'b0, active_out}, 32'd0);

    // randomized traffic against the model
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 4))
        0: t = 32'd0;
        1: t = $urandom_range(1, 40);
        2: t = $urandom_range(100, 3000);
        3: t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: t = $urandom_range(0, 3000);
      endcase
      i = (t > 32'h8000_0000) ? $urandom : $urandom_range(0, 100);
      do_go(t, i);
      n = $urandom_range(5, 900);
      for (int j = 0; j < n; j++) begin
        @(posedge clk); #1;
        stop_in = ($urandom_range(0, 99) < 2);
        go_in = ($urandom_range(0, 199) < 1);
        time_ms_in = $urandom_range(0, 2000);
        inc_ms_in = $urandom_range(0, 50);
      end
      @(posedge clk); #1;
      go_in = 1'b0;
      stop_in = 1'b1;
      @(posedge clk); #1;
      stop_in = 1'b0;
      repeat (3) @(posedge clk);
    end

    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
